// File: rtl/image_resize_pkg.sv
// Shared types for the image size converter frame sequencer.
//   DIM_W_DEF  : default width of every dimension field and counter
//   DATA_W_DEF : default pixel width (RGB888)
//   pixel_t    : one pixel at the default width
//   state_t    : frame sequencer states
package image_resize_pkg;

   localparam int DIM_W_DEF  = 12;
   localparam int DATA_W_DEF = 24;

   typedef logic [DATA_W_DEF-1:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOF,
      ACTIVE,
      DRAIN
   } state_t;

endpackage

// File: rtl/resize_step_acc.sv
// Bresenham keep/drop accumulator for one axis of a nearest-neighbour
// downscaler. Each advance adds step (output size) to the accumulator; when
// the sum reaches modulus (input size) the current sample is kept and the
// modulus is subtracted.
//   clk, reset : clock, synchronous active-high reset
//   step       : output dimension (dst)
//   modulus    : input dimension (src)
//   advance    : consume one sample on this axis
//   clear      : zero the accumulator (wins over advance)
//   keep       : combinational keep decision for the current sample
module resize_step_acc #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] step,
   input  logic [W-1:0] modulus,
   input  logic         advance,
   input  logic         clear,
   output logic         keep
);

   logic [W-1:0] acc;
   logic [W:0]   sx;
   logic [W:0]   diff;

   always_comb begin
      sx   = {1'b0, acc} + {1'b0, step};
      diff = sx - {1'b0, modulus};
      keep = (sx >= {1'b0, modulus});
   end

   // acc stays below modulus, so the wrapped value always fits in W bits
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc <= '0;
      end else if (advance) begin
         acc <= keep ? diff[W-1:0] : sx[W-1:0];
      end
   end

endmodule

// File: rtl/image_resize_ctrl.sv
// Frame-level sequencer for the image size converter: latches the frame
// geometry on start, consumes one AXI4-Stream style input frame and emits the
// nearest-neighbour downscaled frame with regenerated SOF (tuser) / EOL (tlast).
//   ACLK, ARESET            : clock, synchronous active-high reset
//   start, cfg_*            : frame start pulse and geometry from register file
//   s_t*                    : input pixel stream (tuser = SOF, tlast = EOL)
//   m_t*                    : output pixel stream, one register stage
//   busy, done              : frame in progress / one-cycle end-of-frame pulse
//   cfg_err, line_err       : sticky status, cleared by the next legal start
module image_resize_ctrl
   import image_resize_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DIM_W  = DIM_W_DEF
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              start,
   input  logic [DIM_W-1:0]  cfg_src_w,
   input  logic [DIM_W-1:0]  cfg_src_h,
   input  logic [DIM_W-1:0]  cfg_dst_w,
   input  logic [DIM_W-1:0]  cfg_dst_h,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tuser,
   input  logic              s_tlast,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tuser,
   output logic              m_tlast,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              line_err
);

   state_t state_q, state_d;

   logic [DIM_W-1:0] src_w_q, src_h_q, dst_w_q, dst_h_q;
   logic [DIM_W-1:0] col_q, row_q;
   logic             keep_y_line_q;
   logic             first_q;

   logic cfg_ok, start_ok;
   logic beat, proc, col_end, line_first, last_row, eol;
   logic keep_x, keep_y_acc, keep_y_now, keep;

   always_comb begin
      cfg_ok   = (cfg_dst_w != '0) && (cfg_dst_w <= cfg_src_w) &&
                 (cfg_dst_h != '0) && (cfg_dst_h <= cfg_src_h);
      start_ok = (state_q == IDLE) && start && cfg_ok;

      s_tready = ((state_q == WAIT_SOF) || (state_q == ACTIVE)) &&
                 (!m_tvalid || m_tready);
      beat     = s_tvalid && s_tready;
      // The SOF beat in WAIT_SOF is already pixel (0,0); non-SOF beats there are discarded.
      proc     = beat && ((state_q == ACTIVE) || ((state_q == WAIT_SOF) && s_tuser));

      col_end    = (col_q == src_w_q - DIM_W'(1));
      line_first = (col_q == '0);
      last_row   = (row_q == src_h_q - DIM_W'(1));
      eol        = proc && (col_end || s_tlast);

      // Row decision is made on the first pixel of a line and held for the rest of it.
      keep_y_now = line_first ? keep_y_acc : keep_y_line_q;
      keep       = proc && keep_x && keep_y_now;

      busy = (state_q != IDLE);
   end

   resize_step_acc #(.W(DIM_W)) u_acc_x (
      .clk     (ACLK),
      .reset   (ARESET),
      .step    (dst_w_q),
      .modulus (src_w_q),
      .advance (proc),
      .clear   (start_ok || eol),
      .keep    (keep_x)
   );

   resize_step_acc #(.W(DIM_W)) u_acc_y (
      .clk     (ACLK),
      .reset   (ARESET),
      .step    (dst_h_q),
      .modulus (src_h_q),
      .advance (proc && line_first),
      .clear   (start_ok),
      .keep    (keep_y_acc)
   );

   always_ff @(posedge ACLK) begin
      if (ARESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start_ok) state_d = WAIT_SOF;
         WAIT_SOF: if (proc)     state_d = (eol && last_row) ? DRAIN : ACTIVE;
         ACTIVE:   if (eol && last_row) state_d = DRAIN;
         DRAIN:    if (!m_tvalid) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         src_w_q       <= '0;
         src_h_q       <= '0;
         dst_w_q       <= '0;
         dst_h_q       <= '0;
         col_q         <= '0;
         row_q         <= '0;
         keep_y_line_q <= 1'b0;
         first_q       <= 1'b0;
         m_tdata       <= '0;
         m_tvalid      <= 1'b0;
         m_tuser       <= 1'b0;
         m_tlast       <= 1'b0;
         done          <= 1'b0;
         cfg_err       <= 1'b0;
         line_err      <= 1'b0;
      end else begin
         done <= (state_q == DRAIN) && !m_tvalid;

         if ((state_q == IDLE) && start) begin
            if (cfg_ok) begin
               src_w_q  <= cfg_src_w;
               src_h_q  <= cfg_src_h;
               dst_w_q  <= cfg_dst_w;
               dst_h_q  <= cfg_dst_h;
               col_q    <= '0;
               row_q    <= '0;
               first_q  <= 1'b1;
               cfg_err  <= 1'b0;
               line_err <= 1'b0;
            end else begin
               cfg_err <= 1'b1;
            end
         end

         if (proc) begin
            if (eol) begin
               col_q <= '0;
               row_q <= row_q + DIM_W'(1);
            end else begin
               col_q <= col_q + DIM_W'(1);
            end
            if (line_first) keep_y_line_q <= keep_y_acc;
            if ((s_tlast != col_end) || ((state_q == ACTIVE) && s_tuser))
               line_err <= 1'b1;
         end

         // s_tready guarantees the register is free (or emptying) when keep fires.
         if (keep) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s_tdata;
            m_tuser  <= first_q;
            m_tlast  <= eol;
            first_q  <= 1'b0;
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tuser  <= 1'b0;
            m_tlast  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_image_resize_ctrl.sv
// Scoreboard bench for image_resize_ctrl: directed frames push hand-computed
// expected output beats into a queue; a monitor pops and compares on every
// output handshake and also checks data stability while stalled.
module tb_image_resize_ctrl;
   import image_resize_pkg::*;

   localparam int DW = 12;

   typedef struct {
      pixel_t data;
      logic   user;
      logic   last;
   } beat_t;

   logic          ACLK = 1'b0;
   logic          ARESET, start;
   logic [DW-1:0] cfg_src_w, cfg_src_h, cfg_dst_w, cfg_dst_h;
   pixel_t        s_tdata, m_tdata;
   logic          s_tvalid, s_tready, s_tuser, s_tlast;
   logic          m_tvalid, m_tready, m_tuser, m_tlast;
   logic          busy, done, cfg_err, line_err;

   int    checks = 0;
   int    errors = 0;
   int    done_cnt = 0;
   beat_t exp_q[$];
   logic  toggle_en = 1'b0;
   logic  prev_stalled = 1'b0;
   pixel_t prev_data;

   always #5 ACLK = ~ACLK;

   image_resize_ctrl #(.DATA_W(24), .DIM_W(DW)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .start(start),
      .cfg_src_w(cfg_src_w), .cfg_src_h(cfg_src_h),
      .cfg_dst_w(cfg_dst_w), .cfg_dst_h(cfg_dst_h),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_tuser(s_tuser), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tuser(m_tuser), .m_tlast(m_tlast),
      .busy(busy), .done(done), .cfg_err(cfg_err), .line_err(line_err)
   );

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: sampled on the falling edge, inputs only change just after rising edges.
   always @(negedge ACLK) begin
      beat_t e;
      if (ARESET) begin
         prev_stalled = 1'b0;
      end else begin
         if (prev_stalled) begin
            chk("stall_valid", 32'(m_tvalid), 32'd1);
            chk("stall_data", 32'(m_tdata), 32'(prev_data));
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got 0x%0h expected no beat at %0t", m_tdata, $time);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(m_tdata), 32'(e.data));
               chk("out_user", 32'(m_tuser), 32'(e.user));
               chk("out_last", 32'(m_tlast), 32'(e.last));
            end
         end
         if (done) done_cnt++;
         prev_stalled = m_tvalid && !m_tready;
         prev_data    = m_tdata;
      end
   end

   always @(posedge ACLK) begin
      if (toggle_en) begin
         #1 m_tready = ~m_tready;
      end
   end

   task automatic expect_px(input int d, input logic u, input logic l);
      beat_t b;
      b.data = pixel_t'(d);
      b.user = u;
      b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic start_frame(input int sw, input int sh, input int dw, input int dh);
      cfg_src_w = DW'(sw);
      cfg_src_h = DW'(sh);
      cfg_dst_w = DW'(dw);
      cfg_dst_h = DW'(dh);
      start = 1'b1;
      @(posedge ACLK); #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input int d, input logic u, input logic l);
      bit ok = 0;
      s_tdata  = pixel_t'(d);
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge ACLK);
         if (s_tready) begin
            @(posedge ACLK); #1;
            ok = 1;
         end
      end
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      s_tlast  = 1'b0;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_ramp(input int sw, input int sh);
      for (int r = 0; r < sh; r++)
         for (int c = 0; c < sw; c++)
            send_beat(r * sw + c + 1, (r == 0 && c == 0), (c == sw - 1));
   endtask

   task automatic wait_done(input string name);
      int prev = done_cnt;
      for (int n = 0; n < 500 && done_cnt == prev; n++) @(negedge ACLK);
      repeat (3) @(negedge ACLK);
      chk({name, "_done"}, 32'(done_cnt), 32'(prev + 1));
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got still running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      ARESET = 1'b1; start = 1'b0; m_tready = 1'b1;
      cfg_src_w = '0; cfg_src_h = '0; cfg_dst_w = '0; cfg_dst_h = '0;
      s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
      repeat (3) @(posedge ACLK);
      #1;
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_m_tdata", 32'(m_tdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_errs", 32'({cfg_err, line_err}), 32'd0);
      ARESET = 1'b0;
      @(posedge ACLK); #1;

      // Identity 4x4
      for (int i = 1; i <= 16; i++) expect_px(i, (i == 1), (i % 4 == 0));
      start_frame(4, 4, 4, 4);
      chk("id_busy", 32'(busy), 32'd1);
      send_ramp(4, 4);
      wait_done("identity");

      // Half scale 4x4 -> 2x2
      expect_px(6, 1, 0); expect_px(8, 0, 1); expect_px(14, 0, 0); expect_px(16, 0, 1);
      start_frame(4, 4, 2, 2);
      send_ramp(4, 4);
      wait_done("half");

      // Non-integer 5x1 -> 3x1
      expect_px(2, 1, 0); expect_px(4, 0, 0); expect_px(5, 0, 1);
      start_frame(5, 1, 3, 1);
      send_ramp(5, 1);
      wait_done("ratio53");

      // Backpressure on the half-scale case
      expect_px(6, 1, 0); expect_px(8, 0, 1); expect_px(14, 0, 0); expect_px(16, 0, 1);
      toggle_en = 1'b1;
      start_frame(4, 4, 2, 2);
      send_ramp(4, 4);
      wait_done("backpressure");
      toggle_en = 1'b0;
      @(posedge ACLK); #2;
      m_tready = 1'b1;

      // Illegal config
      start_frame(4, 4, 0, 2);
      chk("cfg_err_set", 32'(cfg_err), 32'd1);
      chk("cfg_err_busy", 32'(busy), 32'd0);

      // Early tlast on line 0 (src 4x2, identity scale)
      expect_px(1, 1, 0); expect_px(2, 0, 0); expect_px(3, 0, 1);
      expect_px(4, 0, 0); expect_px(5, 0, 0); expect_px(6, 0, 0); expect_px(7, 0, 1);
      start_frame(4, 2, 4, 2);
      chk("cfg_err_clear", 32'(cfg_err), 32'd0);
      send_beat(1, 1, 0); send_beat(2, 0, 0); send_beat(3, 0, 1);
      send_beat(4, 0, 0); send_beat(5, 0, 0); send_beat(6, 0, 0); send_beat(7, 0, 1);
      wait_done("line_err");
      chk("line_err_set", 32'(line_err), 32'd1);

      // Resync: non-SOF beats before SOF are discarded
      expect_px(1, 1, 0); expect_px(2, 0, 1); expect_px(3, 0, 0); expect_px(4, 0, 1);
      start_frame(2, 2, 2, 2);
      chk("line_err_clear", 32'(line_err), 32'd0);
      send_beat(32'h99, 0, 0); send_beat(32'h98, 0, 0); send_beat(32'h97, 0, 1);
      send_ramp(2, 2);
      wait_done("resync");

      // Reset mid-frame with a stalled output beat
      start_frame(4, 4, 4, 4);
      m_tready = 1'b0;
      send_beat(1, 1, 0);
      chk("mid_valid_before", 32'(m_tvalid), 32'd1);
      ARESET = 1'b1;
      @(posedge ACLK); #1;
      chk("mid_rst_valid", 32'(m_tvalid), 32'd0);
      chk("mid_rst_data", 32'(m_tdata), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(s_tready), 32'd0);
      chk("mid_rst_flags", 32'({m_tuser, m_tlast, done}), 32'd0);
      ARESET = 1'b0;
      m_tready = 1'b1;
      @(posedge ACLK); #1;

      // Fresh frame after reset
      expect_px(4, 1, 1);
      start_frame(2, 2, 1, 1);
      send_ramp(2, 2);
      wait_done("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/image_resize_ctrl.md
Name: image_resize_ctrl

Overview:
- Frame-level sequencer for the image size converter datapath; performs nearest-neighbour downscaling on a pixel stream.
- Latches src/dst dimensions from the AXI4-Lite register file on a start pulse, then consumes one input frame (AXI4-Stream style).
- Decides per pixel keep/drop using Bresenham accumulators and emits the reduced frame with regenerated SOF (tuser) and EOL (tlast).
- Reports done and sticky error status back to the register file.

Parameters:
- DATA_W, 24, pixel data width (RGB888)
- DIM_W, 12, width of every dimension field and counter (max 4095)

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- start  in  1  single-cycle frame start pulse from register file
- cfg_src_w  in  DIM_W  input width in pixels
- cfg_src_h  in  DIM_W  input height in lines
- cfg_dst_w  in  DIM_W  output width
- cfg_dst_h  in  DIM_W  output height
- s_tdata  in  DATA_W  input pixel
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- s_tuser  in  1  start of frame
- s_tlast  in  1  end of line
- m_tdata  out  DATA_W  output pixel
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tuser  out  1  first output pixel of frame
- m_tlast  out  1  last output pixel of line
- busy  out  1  high from accepted start to frame end
- done  out  1  one-cycle pulse at frame end
- cfg_err  out  1  sticky: illegal config at start
- line_err  out  1  sticky: input line-length mismatch

Behaviour:
- Reset: state IDLE; s_tready, m_tvalid, m_tuser, m_tlast, busy, done, cfg_err, line_err = 0; m_tdata = 0; counters and accumulators = 0.
- Config check at start in IDLE:
  - Legal requires 0 < dst_w <= src_w and 0 < dst_h <= src_h.
  - Illegal: set cfg_err, stay IDLE, busy stays 0.
  - Legal: latch all four fields, clear cfg_err and line_err, go to WAIT_SOF, busy = 1.
- start while busy is ignored.
- WAIT_SOF:
  - s_tready = 1; pixels without tuser are discarded.
  - A beat with tuser=1 is processed as pixel (0,0) and moves the FSM to ACTIVE in the same cycle.
- ACTIVE, per accepted beat (s_tvalid & s_tready):
  - Column: sx = acc_x + dst_w (DIM_W+1 bits); keep_x = sx >= src_w; acc_x <= keep_x ? sx - src_w : sx.
  - Row keep_y is evaluated the same way on acc_y at the first pixel of each line and held for that line.
  - Kept pixel = keep_x & keep_y.
  - Consequence: the last column and last row are always kept; exactly dst_w x dst_h pixels are output.
- Output register:
  - One stage. s_tready = !m_tvalid | m_tready (ACTIVE and WAIT_SOF).
  - A kept pixel loads m_tdata and sets m_tvalid on the next edge. Latency is 1 cycle.
  - Dropped pixels are accepted without output.
  - m_tlast = kept at column src_w-1.
  - m_tuser = first kept pixel of the frame.
  - m_tvalid holds until m_tready, with data stable.
- End of line (col == src_w-1 or s_tlast):
  - col <= 0, acc_x <= 0, row++.
  - If s_tlast and col differ in position: set line_err and end the line at whichever comes first.
  - The forced early EOL still emits m_tlast only if that pixel is kept.
- Frame end: EOL of row src_h-1 goes to DRAIN.
  - DRAIN: s_tready = 0 until the output register is empty.
  - Then done pulses 1 cycle, busy = 0, go to IDLE.
- s_tuser seen in ACTIVE mid-frame: set line_err, ignore the tuser, continue.
- ARESET mid-frame: immediate return to reset state; m_tvalid drops without handshake.

Decomposition:
- Shared package image_resize_pkg holds:
  - state enum (IDLE, WAIT_SOF, ACTIVE, DRAIN)
  - DIM_W default
  - pixel typedef
- One sub-module, resize_step_acc: Bresenham accumulator with inputs step, modulus, advance, clear and output keep. Instantiated twice (x, y).

Test Plan:
- Identity: src=dst=4x4, 16 ramped pixels 1..16, m_tready=1 -> all 16 out in order. m_tlast on 4,8,12,16; m_tuser on 1 only; done once.
- Half scale: src 4x4, dst 2x2, pixels 1..16 -> outputs 6,8,14,16. m_tlast on 8 and 16.
- Non-integer ratio: src 5x1, dst 3x1, pixels 1..5 -> outputs 2,4,5. m_tlast on 5.
- Backpressure: half-scale case with m_tready toggling 1/0 each cycle -> same 4 pixels, no loss or duplication, m_tdata stable while stalled.
- Errors:
  - start with dst_w=0 -> cfg_err=1, busy=0.
  - src 4x2 with s_tlast on the 3rd pixel of line 0 -> line_err=1; frame still completes after 2 EOLs with done.
- Resync/reset: 3 beats with tuser=0 before the SOF beat are discarded. ARESET asserted mid-frame -> next cycle all outputs 0, state IDLE, and a fresh start works.
